// File: rtl/mio_pkg.sv
// Shared types and constants for the memory-mapped I/O bridge and its address decoder.
package mio_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  // Default placement of the peripherals in the region-select space.
  localparam int REGION_RAM    = 0;
  localparam int REGION_VRAM   = 1;
  localparam int REGION_PS2    = 2;
  localparam int REGION_SOURCE = 3;
  localparam int REGION_MAP    = 4;
  localparam int REGION_WIN    = 5;
  localparam int REGION_LOSE   = 6;
  localparam int REGION_GPIO   = 7;

  localparam int ERR_CNT_W = 8;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mio_bus_bridge_if.sv
// CPU-side and slave-side bus of the I/O bridge. 'slave' is the bridge's own view,
// 'master' is the view of whatever drives the CPU port and models the peripherals.
interface mio_bus_bridge_if #(
  parameter int NSLAVE = 8,
  parameter int DW     = 32,
  parameter int AW     = 32
) ();

  logic                 cpu_req;
  logic                 cpu_we;
  logic [AW-1:0]        cpu_addr;
  logic [DW-1:0]        cpu_wdata;
  logic                 cpu_busy;
  logic                 cpu_ready;
  logic [DW-1:0]        cpu_rdata;
  logic                 cpu_err;

  logic [NSLAVE-1:0]    slv_req;
  logic                 slv_we;
  logic [AW-1:0]        slv_addr;
  logic [DW-1:0]        slv_wdata;
  logic [NSLAVE-1:0]    slv_ack;
  logic [NSLAVE*DW-1:0] slv_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, slv_ack, slv_rdata,
    input  cpu_busy, cpu_ready, cpu_rdata, cpu_err,
    input  slv_req, slv_we, slv_addr, slv_wdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, slv_ack, slv_rdata,
    output cpu_busy, cpu_ready, cpu_rdata, cpu_err,
    output slv_req, slv_we, slv_addr, slv_wdata
  );

endinterface

// File: rtl/mio_addr_decode.sv
// Region decoder: top SEL_BITS of the address pick a slave; out-of-range selects
// yield an all-zero one-hot vector. Shared with the VRAM arbiter.
module mio_addr_decode
  import mio_pkg::*;
#(
  parameter int NSLAVE   = 8,
  parameter int AW       = 32,
  parameter int SEL_BITS = 4
) (
  input  logic [AW-1:0]       i_addr,
  output logic [SEL_BITS-1:0] o_sel,
  output logic                o_in_range,
  output logic [NSLAVE-1:0]   o_onehot
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default before any branch,
    // otherwise an unassigned path infers a latch.
    o_sel      = i_addr[AW-1 -: SEL_BITS];
    o_in_range = (32'(o_sel) < NSLAVE);
    o_onehot   = '0;
    for (int i = 0; i < NSLAVE; i++) begin
      if (32'(o_sel) == 32'(i)) o_onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/mio_bus_bridge.sv
// Registered request/acknowledge bridge from the CPU data port to NSLAVE peripherals,
// one access in flight, per-access timeout and a saturating error counter.
module mio_bus_bridge
  import mio_pkg::*;
#(
  parameter int NSLAVE   = 8,
  parameter int DW       = 32,
  parameter int AW       = 32,
  parameter int SEL_BITS = 4,
  parameter int TIMEOUT  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  mio_bus_bridge_if.slave      bus,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int                TCNT_W    = $clog2(TIMEOUT);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

  state_e                r_state;
  state_e                w_state_nxt;
  logic [TCNT_W-1:0]     r_tcnt,    w_tcnt_nxt;
  logic [SEL_BITS-1:0]   r_sel,     w_sel_nxt;
  logic                  r_we,      w_we_nxt;
  logic [AW-1:0]         r_addr,    w_addr_nxt;
  logic [DW-1:0]         r_wdata,   w_wdata_nxt;
  logic                  r_busy,    w_busy_nxt;
  logic                  r_ready,   w_ready_nxt;
  logic                  r_err,     w_err_nxt;
  logic [DW-1:0]         r_rdata,   w_rdata_nxt;
  logic [NSLAVE-1:0]     r_slv_req, w_slv_req_nxt;
  logic [ERR_CNT_W-1:0]  r_err_cnt, w_err_cnt_nxt;

  logic [SEL_BITS-1:0]   w_sel;
  logic                  w_in_range;
  logic [NSLAVE-1:0]     w_onehot;
  logic                  w_accept;
  logic                  w_ack;
  logic                  w_timeout;
  logic                  w_resp_err;
  logic [DW-1:0]         w_sel_rdata;

  mio_addr_decode #(
    .NSLAVE   (NSLAVE),
    .AW       (AW),
    .SEL_BITS (SEL_BITS)
  ) u_decode (
    .i_addr     (bus.cpu_addr),
    .o_sel      (w_sel),
    .o_in_range (w_in_range),
    .o_onehot   (w_onehot)
  );

  // Only the ack of the slave currently being requested counts; r_slv_req is one-hot in REQ.
  assign w_ack     = |(bus.slv_ack & r_slv_req);
  assign w_timeout = (r_tcnt == TCNT_LAST);
  assign w_accept  = (r_state == IDLE) && bus.cpu_req;

  always_comb begin
    w_sel_rdata = '0;
    for (int i = 0; i < NSLAVE; i++) begin
      if (32'(r_sel) == 32'(i)) w_sel_rdata = bus.slv_rdata[i*DW +: DW];
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    w_resp_err  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.cpu_req) begin
          if (w_in_range) begin
            w_state_nxt = REQ;
          end else begin
            w_state_nxt = RESP;
            w_resp_err  = 1'b1;
          end
        end
      end
      REQ: begin
        if (w_ack) begin
          w_state_nxt = RESP;
        end else if (w_timeout) begin
          w_state_nxt = RESP;
          w_resp_err  = 1'b1;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Next values of every registered output, derived from the transition being taken.
  always_comb begin
    w_busy_nxt    = (w_state_nxt != IDLE);
    w_ready_nxt   = (w_state_nxt == RESP);
    w_err_nxt     = w_resp_err;
    w_rdata_nxt   = '0;
    w_slv_req_nxt = '0;
    w_tcnt_nxt    = '0;
    w_sel_nxt     = r_sel;
    w_we_nxt      = r_we;
    w_addr_nxt    = r_addr;
    w_wdata_nxt   = r_wdata;
    w_err_cnt_nxt = r_err_cnt;

    if (w_accept) begin
      w_sel_nxt   = w_sel;
      w_we_nxt    = bus.cpu_we;
      w_addr_nxt  = bus.cpu_addr;
      w_wdata_nxt = bus.cpu_wdata;
      if (w_in_range) w_slv_req_nxt = w_onehot;
    end else if (r_state == REQ && w_state_nxt == REQ) begin
      w_slv_req_nxt = r_slv_req;
      w_tcnt_nxt    = r_tcnt + 1'b1;
    end

    if (r_state == REQ && w_ack && !r_we) w_rdata_nxt = w_sel_rdata;
    if (w_ready_nxt && w_resp_err)        w_err_cnt_nxt = sat_inc(r_err_cnt);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous here, so it is tested inside the clocked block and
    // not listed in the sensitivity list.
    if (rst) begin
      // NOTE: state is updated with non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      r_state   <= IDLE;
      r_tcnt    <= '0;
      r_sel     <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_busy    <= 1'b0;
      r_ready   <= 1'b0;
      r_err     <= 1'b0;
      r_rdata   <= '0;
      r_slv_req <= '0;
      r_err_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_tcnt    <= w_tcnt_nxt;
      r_sel     <= w_sel_nxt;
      r_we      <= w_we_nxt;
      r_addr    <= w_addr_nxt;
      r_wdata   <= w_wdata_nxt;
      r_busy    <= w_busy_nxt;
      r_ready   <= w_ready_nxt;
      r_err     <= w_err_nxt;
      r_rdata   <= w_rdata_nxt;
      r_slv_req <= w_slv_req_nxt;
      r_err_cnt <= w_err_cnt_nxt;
    end
  end

  assign bus.cpu_busy  = r_busy;
  assign bus.cpu_ready = r_ready;
  assign bus.cpu_err   = r_err;
  assign bus.cpu_rdata = r_rdata;
  assign bus.slv_req   = r_slv_req;
  assign bus.slv_we    = r_we;
  assign bus.slv_addr  = r_addr;
  assign bus.slv_wdata = r_wdata;
  assign err_cnt       = r_err_cnt;

endmodule

// File: tb/tb_mio_bus_bridge.sv
// Directed bench for mio_bus_bridge: transaction-level timing model checked every cycle,
// plus literal expectations for each scenario.
module tb_mio_bus_bridge;
  import mio_pkg::*;

  localparam int NSLAVE   = 8;
  localparam int DW       = 32;
  localparam int AW       = 32;
  localparam int SEL_BITS = 4;
  localparam int TIMEOUT  = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] err_cnt;

  mio_bus_bridge_if #(.NSLAVE(NSLAVE), .DW(DW), .AW(AW)) bus ();

  mio_bus_bridge #(
    .NSLAVE   (NSLAVE),
    .DW       (DW),
    .AW       (AW),
    .SEL_BITS (SEL_BITS),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic rst_q    = 1'b0;
  logic started  = 1'b0;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rst_q   <= rst;
    started <= 1'b1;
  end

  // Model of the one accepted transaction: acceptance cycle plus slave behaviour.
  bit          m_active = 1'b0;
  int          m_c0, m_sel, m_k;
  bit          m_mapped, m_we;
  logic [31:0] m_addr, m_wdata;
  int          exp_ecnt = 0;
  logic [NSLAVE-1:0] noise_ack = '0;
  logic [31:0] rtab [NSLAVE];

  function automatic bit m_err();
    return !m_mapped || !(m_k >= 0 && m_k < TIMEOUT);
  endfunction

  // Cycles from acceptance to the response strobe.
  function automatic int m_lat();
    if (!m_mapped) return 1;
    if (m_k >= 0 && m_k < TIMEOUT) return m_k + 2;
    return TIMEOUT + 1;
  endfunction

  function automatic bit m_idle(input int c);
    return !m_active || (c > m_c0 + m_lat());
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Slave models: ack exactly k cycles after the first request cycle, plus optional noise.
  always @(posedge clk) begin
    logic [NSLAVE-1:0] a;
    #1;
    a = noise_ack;
    if (m_active && m_mapped && m_k >= 0 && cyc == m_c0 + 1 + m_k) a[m_sel] = 1'b1;
    bus.slv_ack = a;
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic [NSLAVE-1:0] e_req;
    logic [31:0]       e_rdata;
    bit                e_busy, e_ready, e_err;
    int                rc;
    if (started) begin
      e_req   = '0;
      e_rdata = '0;
      e_busy  = 1'b0;
      e_ready = 1'b0;
      e_err   = 1'b0;
      if (rst_q) begin
        m_active = 1'b0;
        exp_ecnt = 0;
        check("rst_slv_we",    bus.slv_we,    0);
        check("rst_slv_addr",  bus.slv_addr,  0);
        check("rst_slv_wdata", bus.slv_wdata, 0);
      end else if (m_active) begin
        rc = m_c0 + m_lat();
        if (cyc > m_c0 && cyc <= rc) e_busy = 1'b1;
        if (m_mapped && cyc > m_c0 && cyc < rc) e_req[m_sel] = 1'b1;
        if (cyc == rc) begin
          e_ready = 1'b1;
          e_err   = m_err();
          e_rdata = (!e_err && !m_we) ? rtab[m_sel] : 32'h0;
          if (e_err && exp_ecnt < 255) exp_ecnt++;
        end
        if (e_busy) begin
          check("slv_we",    bus.slv_we,    m_we);
          check("slv_addr",  bus.slv_addr,  m_addr);
          check("slv_wdata", bus.slv_wdata, m_wdata);
        end
      end
      check("slv_req",   bus.slv_req,   e_req);
      check("cpu_busy",  bus.cpu_busy,  e_busy);
      check("cpu_ready", bus.cpu_ready, e_ready);
      check("cpu_err",   bus.cpu_err,   e_err);
      check("cpu_rdata", bus.cpu_rdata, e_rdata);
      check("err_cnt",   err_cnt,       exp_ecnt);
    end
  end

  task automatic issue(input logic [31:0] addr, input bit we, input logic [31:0] wdata,
                       input int k, output int c0);
    @(posedge clk); #1;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    c0 = cyc;
    if (m_idle(cyc)) begin
      m_active = 1'b1;
      m_c0     = cyc;
      m_sel    = int'(addr[31:28]);
      m_mapped = (m_sel < NSLAVE);
      m_we     = we;
      m_addr   = addr;
      m_wdata  = wdata;
      m_k      = k;
    end
    @(posedge clk); #1;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
  endtask

  task automatic wait_resp(input int c0, input int budget, output int lat,
                           output logic [31:0] rd, output logic er, output int reqc);
    lat  = -1;
    rd   = '0;
    er   = 1'b0;
    reqc = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (|bus.slv_req) reqc++;
      if (bus.cpu_ready) begin
        lat = cyc - c0;
        rd  = bus.cpu_rdata;
        er  = bus.cpu_err;
        break;
      end
    end
    check("resp_seen", 64'(lat >= 0), 1);
  endtask

  initial begin
    int          c0, c1, lat, reqc, nrdy;
    logic [31:0] rd;
    logic        er;

    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.slv_ack   = '0;
    for (int i = 0; i < NSLAVE; i++) begin
      rtab[i] = (i == 0) ? 32'hDEAD_BEEF : 32'hC0DE_0000 + 32'(i);
      bus.slv_rdata[i*DW +: DW] = rtab[i];
    end

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy",    bus.cpu_busy,  0);
    check("reset_ready",   bus.cpu_ready, 0);
    check("reset_slv_req", bus.slv_req,   0);
    check("reset_err_cnt", err_cnt,       0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Read slave 0, ack in the first request cycle.
    issue(32'h0000_0010, 1'b0, 32'h0, 0, c0);
    @(negedge clk);
    check("t1_slv_req_c1", bus.slv_req, 8'h01);
    wait_resp(c0, 40, lat, rd, er, reqc);
    check("t1_latency", lat, 2);
    check("t1_rdata",   rd,  32'hDEAD_BEEF);
    check("t1_err",     er,  0);

    // Write slave 1, ack three cycles late; issued back-to-back.
    issue(32'h1000_0040, 1'b1, 32'h0000_0ABC, 3, c0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t2_slv_we",    bus.slv_we,    1);
      check("t2_slv_wdata", bus.slv_wdata, 32'h0000_0ABC);
      check("t2_slv_req",   bus.slv_req,   8'h02);
    end
    wait_resp(c0, 40, lat, rd, er, reqc);
    check("t2_latency", lat, 5);
    check("t2_rdata",   rd,  0);
    check("t2_err",     er,  0);

    // Slave 2 never acks: timeout.
    issue(32'h2000_0000, 1'b0, 32'h0, -1, c0);
    wait_resp(c0, 40, lat, rd, er, reqc);
    check("t3_req_cycles", reqc, 16);
    check("t3_latency",    lat,  17);
    check("t3_err",        er,   1);
    check("t3_rdata",      rd,   0);
    check("t3_err_cnt",    err_cnt, 1);

    // Ack on the 16th request cycle wins over the timeout.
    issue(32'h2000_0000, 1'b0, 32'h0, 15, c0);
    wait_resp(c0, 40, lat, rd, er, reqc);
    check("t4_latency", lat, 17);
    check("t4_err",     er,  0);
    check("t4_rdata",   rd,  32'hC0DE_0002);
    check("t4_err_cnt", err_cnt, 1);

    // Acks from other slaves are ignored.
    noise_ack = 8'hF7;
    issue(32'h3000_0008, 1'b0, 32'h0, 2, c0);
    wait_resp(c0, 40, lat, rd, er, reqc);
    check("t5_latency", lat, 4);
    check("t5_rdata",   rd,  32'hC0DE_0003);
    check("t5_err",     er,  0);
    noise_ack = '0;

    // Unmapped region, then saturate the error counter.
    issue(32'h9000_0000, 1'b0, 32'h0, -1, c0);
    wait_resp(c0, 10, lat, rd, er, reqc);
    check("t6_latency",  lat,  1);
    check("t6_err",      er,   1);
    check("t6_no_req",   reqc, 0);
    check("t6_err_cnt",  err_cnt, 2);
    for (int n = 1; n < 300; n++) begin
      issue(32'h9000_0000 + 32'(n), 1'b0, 32'h0, -1, c0);
      wait_resp(c0, 10, lat, rd, er, reqc);
    end
    check("t6_err_cnt_sat", err_cnt, 255);

    // Requests while busy are dropped.
    issue(32'h4000_0000, 1'b0, 32'h0, 4, c0);
    issue(32'h5000_0000, 1'b1, 32'h1234, 0, c1);
    issue(32'h6000_0000, 1'b0, 32'h0, 0, c1);
    nrdy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.cpu_ready) nrdy++;
    end
    check("t7_one_ready", nrdy, 1);
    check("t7_err_cnt",   err_cnt, 255);

    // Reset in cycle 3 of a pending access.
    issue(32'h5000_0000, 1'b0, 32'h0, -1, c0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t8_slv_req", bus.slv_req,  0);
    check("t8_busy",    bus.cpu_busy, 0);
    check("t8_err_cnt", err_cnt,      0);
    nrdy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.cpu_ready) nrdy++;
    end
    check("t8_no_ready", nrdy, 0);
    issue(32'h0000_0004, 1'b0, 32'h0, 1, c0);
    wait_resp(c0, 40, lat, rd, er, reqc);
    check("t8_latency", lat, 3);
    check("t8_rdata",   rd,  32'hDEAD_BEEF);
    check("t8_err",     er,  0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
